// File: rtl/ball_game_ctrl.sv
// Arkanoid game sequencer: move-tick pacing for the ball movers,
// serve/play/lost/over/win flow, lives and paddle-hit speed-ups.
module ball_game_ctrl #(
  parameter int TICK_INIT    = 800_000,
  parameter int TICK_MIN     = 200_000,
  parameter int TICK_STEP    = 50_000,
  parameter int HITS_SPEEDUP = 8,
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_TICKS  = 60,
  parameter int Y_LOST       = 767
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic        paddle_hit,
  input  logic [7:0]  bricks_left,
  input  logic [11:0] ball_y,
  output logic        move_tick,
  output logic        ball_run,
  output logic        ball_reload,
  output logic [2:0]  lives,
  output logic [2:0]  game_state,
  output logic        game_over,
  output logic        game_win
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] tick_cnt;
  logic [31:0] period;
  logic [31:0] sped;
  logic [7:0]  hit_cnt;
  logic [7:0]  serve_cnt;
  logic        start_d;
  logic        start_edge;
  logic        active;
  logic        tick_fire;

  assign game_state = state;
  assign start_edge = start_btn & ~start_d;
  assign active     = (state == SERVE) || (state == PLAY);
  assign tick_fire  = active && (tick_cnt == 32'd0);

  // Clamp without ever wrapping below the minimum period
  assign sped = (period >= 32'(TICK_MIN + TICK_STEP))
              ? period - 32'(TICK_STEP)
              : 32'(TICK_MIN);

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lives       <= 3'(LIVES_INIT);
      period      <= 32'(TICK_INIT);
      tick_cnt    <= 32'(TICK_INIT - 1);
      hit_cnt     <= 8'd0;
      serve_cnt   <= 8'd0;
      start_d     <= 1'b0;
      move_tick   <= 1'b0;
      ball_run    <= 1'b0;
      ball_reload <= 1'b0;
      game_over   <= 1'b0;
      game_win    <= 1'b0;
    end else begin
      start_d     <= start_btn;
      ball_reload <= 1'b0;
      move_tick   <= tick_fire;
      if (active)
        tick_cnt <= tick_fire ? period - 32'd1 : tick_cnt - 32'd1;
      else
        tick_cnt <= period - 32'd1;

      unique case (state)
        IDLE, OVER, WIN: begin
          if (start_edge) begin
            state       <= SERVE;
            ball_reload <= 1'b1;
            lives       <= 3'(LIVES_INIT);
            period      <= 32'(TICK_INIT);
            tick_cnt    <= 32'(TICK_INIT - 1);
            hit_cnt     <= 8'd0;
            serve_cnt   <= 8'd0;
            game_over   <= 1'b0;
            game_win    <= 1'b0;
          end
        end
        SERVE: begin
          if (tick_fire) begin
            if (serve_cnt == 8'(SERVE_TICKS - 1)) begin
              state     <= PLAY;
              ball_run  <= 1'b1;
              serve_cnt <= 8'd0;
            end else begin
              serve_cnt <= serve_cnt + 8'd1;
            end
          end
        end
        PLAY: begin
          if (bricks_left == 8'd0) begin
            state     <= WIN;
            ball_run  <= 1'b0;
            game_win  <= 1'b1;
            move_tick <= 1'b0;
          end else if (ball_y >= 12'(Y_LOST)) begin
            state     <= LOST;
            ball_run  <= 1'b0;
            move_tick <= 1'b0;
          end else if (paddle_hit) begin
            if (hit_cnt == 8'(HITS_SPEEDUP - 1)) begin
              hit_cnt <= 8'd0;
              period  <= sped;
            end else begin
              hit_cnt <= hit_cnt + 8'd1;
            end
          end
        end
        LOST: begin
          if (lives <= 3'd1) begin
            state     <= OVER;
            lives     <= 3'd0;
            game_over <= 1'b1;
          end else begin
            state       <= SERVE;
            lives       <= lives - 3'd1;
            ball_reload <= 1'b1;
            period      <= 32'(TICK_INIT);
            tick_cnt    <= 32'(TICK_INIT - 1);
            hit_cnt     <= 8'd0;
            serve_cnt   <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Scoreboard bench for ball_game_ctrl: stimulus queues expected
// output events, a negedge monitor pops and compares them.
module tb_ball_game_ctrl;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start_btn = 1'b0;
  logic        paddle_hit = 1'b0;
  logic [7:0]  bricks_left = 8'd50;
  logic [11:0] ball_y = 12'd100;
  logic        move_tick;
  logic        ball_run;
  logic        ball_reload;
  logic [2:0]  lives;
  logic [2:0]  game_state;
  logic        game_over;
  logic        game_win;

  ball_game_ctrl #(
    .TICK_INIT(10),
    .TICK_MIN(4),
    .TICK_STEP(3),
    .HITS_SPEEDUP(2),
    .LIVES_INIT(2),
    .SERVE_TICKS(2),
    .Y_LOST(767)
  ) dut (
    .pclk(pclk),
    .reset_n(reset_n),
    .start_btn(start_btn),
    .paddle_hit(paddle_hit),
    .bricks_left(bricks_left),
    .ball_y(ball_y),
    .move_tick(move_tick),
    .ball_run(ball_run),
    .ball_reload(ball_reload),
    .lives(lives),
    .game_state(game_state),
    .game_over(game_over),
    .game_win(game_win)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] lv;
    logic       tk;
    logic       rl;
    logic       run;
    logic       ov;
    logic       wn;
    logic [7:0] gap;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        act;
  ev_t        want;
  int         total = 0;
  int         bad = 0;
  int         evn = 0;
  int         gcnt = 0;
  logic [2:0] prev_st = 3'd0;

  function automatic ev_t mk(input logic [2:0] st, input logic [2:0] lv,
                             input logic tk, input logic rl,
                             input logic [7:0] gap);
    ev_t e;
    e.st  = st;
    e.lv  = lv;
    e.tk  = tk;
    e.rl  = rl;
    e.run = (st == 3'd2);
    e.ov  = (st == 3'd4);
    e.wn  = (st == 3'd5);
    e.gap = gap;
    return e;
  endfunction

  // Any tick, reload or state change is an output event
  always @(negedge pclk) begin
    gcnt = gcnt + 1;
    if (move_tick || ball_reload || game_state != prev_st) begin
      act.st  = game_state;
      act.lv  = lives;
      act.tk  = move_tick;
      act.rl  = ball_reload;
      act.run = ball_run;
      act.ov  = game_over;
      act.wn  = game_win;
      act.gap = move_tick ? 8'(gcnt) : 8'd0;
      evn = evn + 1;
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_event#%0d: got st=%0d lv=%0d tk=%0b rl=%0b gap=%0d, want no event",
                 evn, act.st, act.lv, act.tk, act.rl, act.gap);
      end else begin
        want = exp_q.pop_front();
        if (act !== want) begin
          bad = bad + 1;
          $display("FAIL event#%0d: got st=%0d lv=%0d tk=%0b rl=%0b run=%0b ov=%0b wn=%0b gap=%0d, want st=%0d lv=%0d tk=%0b rl=%0b run=%0b ov=%0b wn=%0b gap=%0d",
                   evn, act.st, act.lv, act.tk, act.rl, act.run, act.ov, act.wn, act.gap,
                   want.st, want.lv, want.tk, want.rl, want.run, want.ov, want.wn, want.gap);
        end
      end
    end
    if (move_tick || ball_reload || !reset_n) gcnt = 0;
    prev_st = game_state;
  end

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: pending=%0d after %0d cycles, want 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic hit();
    paddle_hit = 1'b1;
    step();
    paddle_hit = 1'b0;
    step();
  endtask

  task automatic push_serve(input logic [2:0] lv);
    exp_q.push_back(mk(3'd1, lv, 1'b0, 1'b1, 8'd0));
    exp_q.push_back(mk(3'd1, lv, 1'b1, 1'b0, 8'd10));
    exp_q.push_back(mk(3'd2, lv, 1'b1, 1'b0, 8'd10));
  endtask

  task automatic push_lost(input logic [2:0] lv);
    exp_q.push_back(mk(3'd3, lv, 1'b0, 1'b0, 8'd0));
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Serve from IDLE, start held high afterwards
    push_serve(3'd2);
    start_btn = 1'b1;
    drain(60);

    // Speed-ups: gaps 10 -> 7 -> 4 -> 4
    exp_q.push_back(mk(3'd2, 3'd2, 1'b1, 1'b0, 8'd10));
    hit();
    hit();
    drain(40);
    exp_q.push_back(mk(3'd2, 3'd2, 1'b1, 1'b0, 8'd7));
    hit();
    hit();
    drain(40);
    exp_q.push_back(mk(3'd2, 3'd2, 1'b1, 1'b0, 8'd4));
    hit();
    hit();
    drain(40);
    exp_q.push_back(mk(3'd2, 3'd2, 1'b1, 1'b0, 8'd4));
    drain(40);
    start_btn = 1'b0;

    // Lose a ball: back to serve with lives 1
    push_lost(3'd2);
    push_serve(3'd1);
    ball_y = 12'd767;
    step();
    ball_y = 12'd100;
    drain(60);

    // Lose the last ball: game over, quiet afterwards
    push_lost(3'd1);
    exp_q.push_back(mk(3'd4, 3'd0, 1'b0, 1'b0, 8'd0));
    ball_y = 12'd767;
    step();
    ball_y = 12'd100;
    drain(20);
    repeat (30) step();

    // Restart from OVER
    push_serve(3'd2);
    start_btn = 1'b1;
    drain(60);

    // Win beats lost and the hit in the same cycle
    exp_q.push_back(mk(3'd5, 3'd2, 1'b0, 1'b0, 8'd0));
    bricks_left = 8'd0;
    ball_y = 12'd800;
    paddle_hit = 1'b1;
    step();
    paddle_hit = 1'b0;
    drain(20);
    repeat (20) step();
    bricks_left = 8'd50;
    ball_y = 12'd100;

    // Restart from WIN, lose one life, then reset mid-PLAY
    start_btn = 1'b0;
    step();
    push_serve(3'd2);
    start_btn = 1'b1;
    drain(60);
    push_lost(3'd2);
    push_serve(3'd1);
    ball_y = 12'd767;
    step();
    ball_y = 12'd100;
    drain(60);
    hit();
    exp_q.push_back(mk(3'd0, 3'd2, 1'b0, 1'b0, 8'd0));
    reset_n = 1'b0;
    start_btn = 1'b0;
    drain(5);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
